// File: rtl/fruit_spawner_if.sv
// Fruit spawner signal bundle: frame/collision inputs in, fruit placement out.
interface fruit_spawner_if;
  logic        startOfFrame;
  logic        fruitEaten;
  logic        overlapObstacle;
  logic [10:0] randomX;
  logic [10:0] randomY;
  logic        placeNew;
  logic        fruitActive;
  logic [7:0]  eatenCount;

  // Spawner side: produces the fruit position and status.
  modport master (
    input  startOfFrame,
    input  fruitEaten,
    input  overlapObstacle,
    output randomX,
    output randomY,
    output placeNew,
    output fruitActive,
    output eatenCount
  );

  // Game side: supplies frame timing and collision information.
  modport slave (
    output startOfFrame,
    output fruitEaten,
    output overlapObstacle,
    input  randomX,
    input  randomY,
    input  placeNew,
    input  fruitActive,
    input  eatenCount
  );
endinterface

// File: rtl/fruit_spawner.sv
// Fruit spawner: picks pseudo-random fruit positions inside a legal window,
// re-rolls positions that land on obstacles, counts eaten fruits and waits a
// fixed number of frames before spawning the next fruit.
module fruit_spawner #(
  parameter int X_MIN          = 32,
  parameter int X_SPAN         = 544,
  parameter int Y_MIN          = 32,
  parameter int Y_SPAN         = 384,
  parameter int RESPAWN_FRAMES = 60,
  parameter int MAX_RETRIES    = 7
) (
  input logic             clk,
  input logic             resetN,
  fruit_spawner_if.master bus
);

  typedef enum logic [1:0] {SPAWN, VERIFY, ACTIVE, WAIT} state_t;

  localparam logic [15:0] LFSR_SEED   = 16'hACE1;
  localparam logic [10:0] X_MIN_W     = 11'(X_MIN);
  localparam logic [10:0] X_SPAN_W    = 11'(X_SPAN);
  localparam logic [10:0] Y_MIN_W     = 11'(Y_MIN);
  localparam logic [10:0] Y_SPAN_W    = 11'(Y_SPAN);
  localparam logic [7:0]  FRAMES_LAST = 8'(RESPAWN_FRAMES - 1);
  localparam logic [3:0]  RETRY_LIMIT = 4'(MAX_RETRIES);

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [10:0] rand_x_q, rand_x_d;
  logic [10:0] rand_y_q, rand_y_d;
  logic        place_new_q, place_new_d;
  logic        fruit_active_q, fruit_active_d;
  logic [7:0]  eaten_cnt_q, eaten_cnt_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [3:0]  retries_q, retries_d;
  logic        overlap_q, overlap_d;
  logic        ovl_seen;

  // Fold a 10-bit random value into the X window with a single subtraction;
  // X_SPAN > 512 guarantees one fold is always enough.
  function automatic logic [10:0] fold_x(input logic [9:0] raw);
    logic [10:0] c;
    c = {1'b0, raw};
    if (c >= X_SPAN_W) c = c - X_SPAN_W;
    return c + X_MIN_W;
  endfunction

  // Same single-fold scheme for the 9-bit Y value (Y_SPAN > 256).
  function automatic logic [10:0] fold_y(input logic [8:0] raw);
    logic [10:0] c;
    c = {2'b00, raw};
    if (c >= Y_SPAN_W) c = c - Y_SPAN_W;
    return c + Y_MIN_W;
  endfunction

  // Next-state logic: LFSR free-runs; FSM handles spawn/verify/active/wait.
  always_comb begin
    lfsr_d         = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    state_d        = state_q;
    rand_x_d       = rand_x_q;
    rand_y_d       = rand_y_q;
    place_new_d    = 1'b0;
    fruit_active_d = fruit_active_q;
    eaten_cnt_d    = eaten_cnt_q;
    frame_cnt_d    = frame_cnt_q;
    retries_d      = retries_q;
    overlap_d      = overlap_q;
    // Overlap seen on the deciding clk itself still counts.
    ovl_seen       = overlap_q | bus.overlapObstacle;
    case (state_q)
      SPAWN: begin
        rand_x_d       = fold_x(lfsr_q[9:0]);
        rand_y_d       = fold_y(lfsr_q[15:7]);
        place_new_d    = 1'b1;
        fruit_active_d = 1'b1;
        frame_cnt_d    = 8'd0;
        state_d        = VERIFY;
      end
      VERIFY: begin
        overlap_d = ovl_seen;
        if (bus.startOfFrame) begin
          if (frame_cnt_q == 8'd1) begin
            frame_cnt_d = 8'd0;
            if (ovl_seen && (retries_q < RETRY_LIMIT)) begin
              // Re-roll: the new position gets a fresh overlap verdict.
              retries_d = retries_q + 4'd1;
              overlap_d = 1'b0;
              state_d   = SPAWN;
            end else begin
              state_d = ACTIVE;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
      end
      ACTIVE: begin
        // Eating wins over a coincident frame pulse; that pulse is dropped.
        if (bus.fruitEaten) begin
          if (eaten_cnt_q != 8'hFF) eaten_cnt_d = eaten_cnt_q + 8'd1;
          fruit_active_d = 1'b0;
          frame_cnt_d    = 8'd0;
          state_d        = WAIT;
        end
      end
      WAIT: begin
        if (bus.startOfFrame) begin
          if (frame_cnt_q == FRAMES_LAST) begin
            retries_d   = 4'd0;
            overlap_d   = 1'b0;
            frame_cnt_d = 8'd0;
            state_d     = SPAWN;
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = SPAWN;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q        <= SPAWN;
      lfsr_q         <= LFSR_SEED;
      rand_x_q       <= X_MIN_W;
      rand_y_q       <= Y_MIN_W;
      place_new_q    <= 1'b0;
      fruit_active_q <= 1'b0;
      eaten_cnt_q    <= 8'd0;
      frame_cnt_q    <= 8'd0;
      retries_q      <= 4'd0;
      overlap_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      lfsr_q         <= lfsr_d;
      rand_x_q       <= rand_x_d;
      rand_y_q       <= rand_y_d;
      place_new_q    <= place_new_d;
      fruit_active_q <= fruit_active_d;
      eaten_cnt_q    <= eaten_cnt_d;
      frame_cnt_q    <= frame_cnt_d;
      retries_q      <= retries_d;
      overlap_q      <= overlap_d;
    end
  end

  assign bus.randomX     = rand_x_q;
  assign bus.randomY     = rand_y_q;
  assign bus.placeNew    = place_new_q;
  assign bus.fruitActive = fruit_active_q;
  assign bus.eatenCount  = eaten_cnt_q;

endmodule

// File: tb/tb_fruit_spawner.sv
// Directed testbench for fruit_spawner.
module tb_fruit_spawner;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  fruit_spawner_if bus ();
  fruit_spawner_if bus2 ();

  fruit_spawner dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  fruit_spawner #(.RESPAWN_FRAMES(1)) dut2 (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus2)
  );

  int errors = 0;
  int checks = 0;

  // Reference LFSR and window folding (default parameters).
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [31:0] cand_x(input logic [15:0] s);
    logic [31:0] c;
    c = {22'd0, s[9:0]};
    if (c >= 32'd544) c = c - 32'd544;
    return c + 32'd32;
  endfunction

  function automatic logic [31:0] cand_y(input logic [15:0] s);
    logic [31:0] c;
    c = {23'd0, s[15:7]};
    if (c >= 32'd384) c = c - 32'd384;
    return c + 32'd32;
  endfunction

  logic [15:0] m_lfsr, m_prev;
  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      m_lfsr <= 16'hACE1;
      m_prev <= 16'hACE1;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= lfsr_next(m_lfsr);
    end
  end

  // placeNew monitor: counts pulses, back-to-back pulses, and the expected
  // position of the most recent spawn.
  int          pn_count = 0;
  int          pn_consec = 0;
  logic        pn_prev = 1'b0;
  logic [31:0] exp_x = 32'd0;
  logic [31:0] exp_y = 32'd0;
  always @(negedge clk) begin
    if (bus.placeNew === 1'b1) begin
      pn_count = pn_count + 1;
      if (pn_prev) pn_consec = pn_consec + 1;
      exp_x = cand_x(m_prev);
      exp_y = cand_y(m_prev);
    end
    pn_prev = (bus.placeNew === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sof_pulse();
    bus.startOfFrame = 1'b1;
    step();
    bus.startOfFrame = 1'b0;
  endtask

  task automatic sof2_pulse();
    bus2.startOfFrame = 1'b1;
    step();
    bus2.startOfFrame = 1'b0;
  endtask

  int base;

  initial begin
    bus.startOfFrame     = 1'b0;
    bus.fruitEaten       = 1'b0;
    bus.overlapObstacle  = 1'b0;
    bus2.startOfFrame    = 1'b0;
    bus2.fruitEaten      = 1'b0;
    bus2.overlapObstacle = 1'b0;

    // Reset values
    repeat (3) step();
    check("rst_x", 32'(bus.randomX), 32'd32);
    check("rst_y", 32'(bus.randomY), 32'd32);
    check("rst_place", 32'(bus.placeNew), 32'd0);
    check("rst_active", 32'(bus.fruitActive), 32'd0);
    check("rst_eaten", 32'(bus.eatenCount), 32'd0);

    // First spawn from seed ACE1: cx=225 -> 257, cy=345 -> 377
    #2 resetN = 1'b1;
    step();
    check("spawn0_place", 32'(bus.placeNew), 32'd1);
    check("spawn0_x", 32'(bus.randomX), 32'd257);
    check("spawn0_y", 32'(bus.randomY), 32'd377);
    check("spawn0_active", 32'(bus.fruitActive), 32'd1);
    step();
    check("spawn0_place_single", 32'(bus.placeNew), 32'd0);

    // VERIFY ignores fruitEaten
    bus.fruitEaten = 1'b1;
    step();
    step();
    bus.fruitEaten = 1'b0;
    check("verify_eat_ignored", 32'(bus.eatenCount), 32'd0);
    sof_pulse();
    step();
    check("verify_active", 32'(bus.fruitActive), 32'd1);
    sof_pulse();

    // ACTIVE: eat coinciding with a frame pulse, held 5 clks
    bus.fruitEaten   = 1'b1;
    bus.startOfFrame = 1'b1;
    step();
    bus.startOfFrame = 1'b0;
    check("eat_count", 32'(bus.eatenCount), 32'd1);
    check("eat_inactive", 32'(bus.fruitActive), 32'd0);
    repeat (4) step();
    bus.fruitEaten = 1'b0;
    check("eat_count_held", 32'(bus.eatenCount), 32'd1);

    // WAIT: 59 pulses must not respawn (coincident pulse not counted)
    base = pn_count;
    repeat (59) begin
      sof_pulse();
      step();
    end
    check("wait_no_spawn", 32'(pn_count - base), 32'd0);
    check("wait_inactive", 32'(bus.fruitActive), 32'd0);
    check("wait_x_hold", 32'(bus.randomX), 32'd257);
    sof_pulse();
    check("wait_60_place_lat", 32'(bus.placeNew), 32'd0);
    step();
    check("respawn_place", 32'(bus.placeNew), 32'd1);
    check("respawn_x", 32'(bus.randomX), cand_x(m_prev));
    check("respawn_y", 32'(bus.randomY), cand_y(m_prev));
    check("respawn_x_window", 32'((bus.randomX >= 11'd32) && (bus.randomX <= 11'd575)), 32'd1);
    check("respawn_y_window", 32'((bus.randomY >= 11'd32) && (bus.randomY <= 11'd415)), 32'd1);

    // Obstacle held forever: 7 retries then ACTIVE with last position
    bus.overlapObstacle = 1'b1;
    step();
    base = pn_count;
    repeat (8) begin
      sof_pulse();
      step();
      sof_pulse();
      step();
      step();
      step();
    end
    check("retry_spawns", 32'(pn_count - base), 32'd7);
    check("retry_final_x", 32'(bus.randomX), exp_x);
    check("retry_final_y", 32'(bus.randomY), exp_y);
    check("retry_active", 32'(bus.fruitActive), 32'd1);
    repeat (4) begin
      sof_pulse();
      step();
    end
    check("retry_exhausted", 32'(pn_count - base), 32'd7);

    // Eat, then reset during WAIT frame 30
    bus.overlapObstacle = 1'b0;
    bus.fruitEaten = 1'b1;
    step();
    bus.fruitEaten = 1'b0;
    check("eat2_count", 32'(bus.eatenCount), 32'd2);
    repeat (29) begin
      sof_pulse();
      step();
    end
    check("wait30_no_spawn", 32'(pn_count - base), 32'd7);
    resetN = 1'b0;
    #1;
    check("midrst_eaten", 32'(bus.eatenCount), 32'd0);
    check("midrst_active", 32'(bus.fruitActive), 32'd0);
    check("midrst_x", 32'(bus.randomX), 32'd32);
    check("midrst_y", 32'(bus.randomY), 32'd32);
    check("midrst_place", 32'(bus.placeNew), 32'd0);
    step();
    #2 resetN = 1'b1;
    step();
    check("postrst_place", 32'(bus.placeNew), 32'd1);
    check("postrst_x", 32'(bus.randomX), 32'd257);
    check("postrst_y", 32'(bus.randomY), 32'd377);

    // Saturation on the RESPAWN_FRAMES=1 instance
    for (int i = 1; i <= 300; i++) begin
      sof2_pulse();
      sof2_pulse();
      bus2.fruitEaten = 1'b1;
      step();
      bus2.fruitEaten = 1'b0;
      sof2_pulse();
      step();
      if (i == 254) check("sat_254", 32'(bus2.eatenCount), 32'd254);
    end
    check("sat_300", 32'(bus2.eatenCount), 32'd255);

    // Extreme candidate: LFSR all ones gives cx=1023, cy=511
    resetN = 1'b0;
    force dut.lfsr_q = 16'hFFFF;
    step();
    #2 resetN = 1'b1;
    step();
    release dut.lfsr_q;
    check("fold_place", 32'(bus.placeNew), 32'd1);
    check("fold_x", 32'(bus.randomX), 32'd511);
    check("fold_y", 32'(bus.randomY), 32'd159);

    step();
    check("place_never_consecutive", 32'(pn_consec), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
